// File: rtl/encode_8_3_seq.sv
// Sequential 8-to-3 priority encoder with a valid/ack handshake.
// Request lines are latched into a sticky pending register. The highest
// pending line is granted and its code is held on C until acknowledged.
// C uses the bit order of the team's 3-to-8 decoder input, so looping C
// back into that decoder (En=1) asserts the granted line's output.
module encode_8_3_seq (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] D,
    input  logic       En,
    input  logic       Ack,
    output logic [2:0] C,
    output logic       Valid,
    output logic [7:0] Pend,
    output logic       Ovr
);

    typedef enum logic {
        IDLE = 1'b0,
        HOLD = 1'b1
    } state_t;

    state_t     state_q, state_d;
    logic [7:0] pend_q, pend_d;
    logic [2:0] code_q, code_d;
    logic [2:0] grantIdx_q, grantIdx_d;
    logic       ovr_q, ovr_d;

    logic [2:0] topIdx;
    logic [7:0] clrMask;

    // The code value read MSB-first from C[0] is 7-k, which for three bits
    // is simply ~k; the bits are then reversed into the decoder's order.
    function automatic logic [2:0] lineToCode(input logic [2:0] line);
        logic [2:0] v;
        v = ~line;
        return {v[0], v[1], v[2]};
    endfunction

    // Find the highest-index pending line; later (higher) hits override.
    always_comb begin
        topIdx = '0;
        for (int k = 0; k < 8; k++) begin
            if (pend_q[k]) begin
                topIdx = 3'(k);
            end
        end
    end

    // One-hot clear mask for the granted line when the handshake completes.
    always_comb begin
        clrMask = '0;
        if (state_q == HOLD && Ack) begin
            clrMask[grantIdx_q] = 1'b1;
        end
    end

    // Next-state logic: pending/overrun update and the grant handshake FSM.
    always_comb begin
        state_d    = state_q;
        code_d     = code_q;
        grantIdx_d = grantIdx_q;
        pend_d     = (pend_q & ~clrMask) | D;
        ovr_d      = ovr_q | (|(D & pend_q & ~clrMask));

        unique case (state_q)
            IDLE: begin
                if (En && (pend_q != 8'h00)) begin
                    state_d    = HOLD;
                    grantIdx_d = topIdx;
                    code_d     = lineToCode(topIdx);
                end
            end
            HOLD: begin
                if (Ack) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State register with synchronous reset; reset overrides D and Ack.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            pend_q     <= 8'h00;
            code_q     <= 3'b000;
            grantIdx_q <= 3'b000;
            ovr_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            pend_q     <= pend_d;
            code_q     <= code_d;
            grantIdx_q <= grantIdx_d;
            ovr_q      <= ovr_d;
        end
    end

    assign C     = code_q;
    assign Valid = (state_q == HOLD);
    assign Pend  = pend_q;
    assign Ovr   = ovr_q;

endmodule

// File: tb/tb_encode_8_3_seq.sv
// Testbench for encode_8_3_seq: directed scenarios with literal expectations
// followed by randomized traffic, all checked against a behavioural model.
module tb_encode_8_3_seq;

    logic       clk;
    logic       rst;
    logic [7:0] D;
    logic       En;
    logic       Ack;
    logic [2:0] C;
    logic       Valid;
    logic [7:0] Pend;
    logic       Ovr;

    int checks;
    int errors;

    // Behavioural model state: pending set, grant status, code number, overrun.
    logic [7:0] mPend, nPend;
    logic       mValid, nValid;
    logic [2:0] mLine, nLine;
    int         mCodeNum, nCodeNum;
    logic       mOvr, nOvr;
    logic [7:0] mClr;
    int         mHigh;

    encode_8_3_seq dut (
        .clk  (clk),
        .rst  (rst),
        .D    (D),
        .En   (En),
        .Ack  (Ack),
        .C    (C),
        .Valid(Valid),
        .Pend (Pend),
        .Ovr  (Ovr)
    );

    // Free-running clock, 10 time units per period.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Numeric value of a code as the consumer reads it: C[0] is the MSB.
    function automatic int codeValue(input logic [2:0] c);
        return int'(c[0]) * 4 + int'(c[1]) * 2 + int'(c[2]);
    endfunction

    // Reference 3-to-8 decoder: code value v selects output line 7-v.
    function automatic logic [7:0] decode3to8(input logic [2:0] c, input logic en);
        if (!en) return 8'h00;
        return 8'(1 << (7 - codeValue(c)));
    endfunction

    // Index of the most significant set bit, by repeated halving.
    function automatic int highestLine(input logic [7:0] p);
        int v;
        int h;
        v = int'(p);
        h = 0;
        while (v > 1) begin
            v = v / 2;
            h++;
        end
        return h;
    endfunction

    // Model next-state: what the encoder must do on the coming edge.
    always_comb begin
        mClr     = 8'h00;
        mHigh    = highestLine(mPend);
        nValid   = mValid;
        nLine    = mLine;
        nCodeNum = mCodeNum;
        nOvr     = mOvr;
        if (mValid && Ack) mClr = 8'(1 << mLine);
        nPend = (mPend & ~mClr) | D;
        if ((D & mPend & ~mClr) != 8'h00) nOvr = 1'b1;
        if (mValid) begin
            if (Ack) nValid = 1'b0;
        end else if (En && mPend != 8'h00) begin
            nValid   = 1'b1;
            nLine    = 3'(mHigh);
            nCodeNum = 7 - mHigh;
        end
    end

    // Model state register, reset alongside the DUT.
    always @(posedge clk) begin
        if (rst) begin
            mPend    <= 8'h00;
            mValid   <= 1'b0;
            mLine    <= 3'd0;
            mCodeNum <= 0;
            mOvr     <= 1'b0;
        end else begin
            mPend    <= nPend;
            mValid   <= nValid;
            mLine    <= nLine;
            mCodeNum <= nCodeNum;
            mOvr     <= nOvr;
        end
    end

    // Drive one set of inputs and let exactly one rising edge consume them.
    task automatic applyStimulus(input logic [7:0] d, input logic en,
                                 input logic ack, input logic r);
        D   = d;
        En  = en;
        Ack = ack;
        rst = r;
        @(posedge clk);
        #1;
    endtask

    // Compare DUT outputs with hand-computed literal expectations.
    task automatic checkOutput(input string name, input logic expValid,
                               input logic [2:0] expC, input logic [7:0] expPend,
                               input logic expOvr);
        checks++;
        if (Valid !== expValid) begin
            errors++;
            $display("[TB] FAIL %s Valid: got %b expected %b", name, Valid, expValid);
        end
        checks++;
        if (C !== expC) begin
            errors++;
            $display("[TB] FAIL %s C: got %b expected %b", name, C, expC);
        end
        checks++;
        if (Pend !== expPend) begin
            errors++;
            $display("[TB] FAIL %s Pend: got %h expected %h", name, Pend, expPend);
        end
        checks++;
        if (Ovr !== expOvr) begin
            errors++;
            $display("[TB] FAIL %s Ovr: got %b expected %b", name, Ovr, expOvr);
        end
    endtask

    initial begin
        logic [7:0] rd;
        checks = 0;
        errors = 0;
        D   = 8'h00;
        En  = 1'b0;
        Ack = 1'b0;
        rst = 1'b1;
        @(posedge clk);
        #1;

        // Every-cycle comparison of the DUT against the model.
        fork
            forever begin
                @(negedge clk);
                checks++;
                if (Valid !== mValid) begin
                    errors++;
                    $display("[TB] FAIL model Valid: got %b expected %b", Valid, mValid);
                end
                checks++;
                if (Pend !== mPend) begin
                    errors++;
                    $display("[TB] FAIL model Pend: got %h expected %h", Pend, mPend);
                end
                checks++;
                if (Ovr !== mOvr) begin
                    errors++;
                    $display("[TB] FAIL model Ovr: got %b expected %b", Ovr, mOvr);
                end
                checks++;
                if ($isunknown(C) || codeValue(C) != mCodeNum) begin
                    errors++;
                    $display("[TB] FAIL model C: got value %0d expected value %0d", codeValue(C), mCodeNum);
                end
            end
        join_none

        applyStimulus(8'h00, 1'b1, 1'b0, 1'b1);
        checkOutput("reset", 1'b0, 3'b000, 8'h00, 1'b0);

        // Single request on line 0, held for five cycles then acknowledged.
        applyStimulus(8'h01, 1'b1, 1'b0, 1'b0);
        checkOutput("single latch", 1'b0, 3'b000, 8'h01, 1'b0);
        applyStimulus(8'h00, 1'b1, 1'b0, 1'b0);
        checkOutput("single grant", 1'b1, 3'b111, 8'h01, 1'b0);
        for (int i = 0; i < 5; i++) begin
            applyStimulus(8'h00, 1'b1, 1'b0, 1'b0);
            checkOutput("single hold", 1'b1, 3'b111, 8'h01, 1'b0);
        end
        applyStimulus(8'h00, 1'b1, 1'b1, 1'b0);
        checkOutput("single ack", 1'b0, 3'b111, 8'h00, 1'b0);

        // Priority order for lines 5, 4, 1 with Ack held high throughout.
        applyStimulus(8'h32, 1'b1, 1'b1, 1'b0);
        checkOutput("prio latch", 1'b0, 3'b111, 8'h32, 1'b0);
        applyStimulus(8'h00, 1'b1, 1'b1, 1'b0);
        checkOutput("prio k5", 1'b1, 3'b010, 8'h32, 1'b0);
        applyStimulus(8'h00, 1'b1, 1'b1, 1'b0);
        checkOutput("prio ack5", 1'b0, 3'b010, 8'h12, 1'b0);
        applyStimulus(8'h00, 1'b1, 1'b1, 1'b0);
        checkOutput("prio k4", 1'b1, 3'b110, 8'h12, 1'b0);
        applyStimulus(8'h00, 1'b1, 1'b1, 1'b0);
        applyStimulus(8'h00, 1'b1, 1'b1, 1'b0);
        checkOutput("prio k1", 1'b1, 3'b011, 8'h02, 1'b0);
        applyStimulus(8'h00, 1'b1, 1'b1, 1'b0);
        checkOutput("prio done", 1'b0, 3'b011, 8'h00, 1'b0);

        // No preemption by line 7 while line 0 is held, then overrun.
        applyStimulus(8'h01, 1'b1, 1'b0, 1'b0);
        applyStimulus(8'h00, 1'b1, 1'b0, 1'b0);
        applyStimulus(8'h80, 1'b1, 1'b0, 1'b0);
        checkOutput("nopreempt", 1'b1, 3'b111, 8'h81, 1'b0);
        applyStimulus(8'h80, 1'b1, 1'b0, 1'b0);
        checkOutput("overrun", 1'b1, 3'b111, 8'h81, 1'b1);
        applyStimulus(8'h00, 1'b1, 1'b1, 1'b0);
        applyStimulus(8'h00, 1'b1, 1'b0, 1'b0);
        checkOutput("after ovr k7", 1'b1, 3'b000, 8'h80, 1'b1);
        applyStimulus(8'h00, 1'b1, 1'b1, 1'b0);

        // Reset in the middle of a grant with Pend=A0 and Ack asserted.
        applyStimulus(8'hA0, 1'b1, 1'b0, 1'b0);
        applyStimulus(8'h00, 1'b1, 1'b0, 1'b0);
        checkOutput("pre reset hold", 1'b1, 3'b000, 8'hA0, 1'b1);
        applyStimulus(8'hFF, 1'b1, 1'b1, 1'b1);
        checkOutput("mid reset", 1'b0, 3'b000, 8'h00, 1'b0);

        // Same-edge acknowledge and re-request on line 3.
        applyStimulus(8'h08, 1'b1, 1'b0, 1'b0);
        applyStimulus(8'h00, 1'b1, 1'b0, 1'b0);
        checkOutput("k3 grant", 1'b1, 3'b001, 8'h08, 1'b0);
        applyStimulus(8'h08, 1'b1, 1'b1, 1'b0);
        checkOutput("k3 rereq", 1'b0, 3'b001, 8'h08, 1'b0);
        applyStimulus(8'h00, 1'b1, 1'b0, 1'b0);
        checkOutput("k3 regrant", 1'b1, 3'b001, 8'h08, 1'b0);
        applyStimulus(8'h00, 1'b1, 1'b1, 1'b0);

        // Enable gating, decoder loopback, and En dropping during a grant.
        applyStimulus(8'h44, 1'b0, 1'b0, 1'b0);
        applyStimulus(8'h00, 1'b0, 1'b0, 1'b0);
        checkOutput("en gated", 1'b0, 3'b001, 8'h44, 1'b0);
        applyStimulus(8'h00, 1'b1, 1'b0, 1'b0);
        checkOutput("en k6", 1'b1, 3'b100, 8'h44, 1'b0);
        checks++;
        if (decode3to8(C, 1'b1) !== 8'h40) begin
            errors++;
            $display("[TB] FAIL loopback: got %h expected %h", decode3to8(C, 1'b1), 8'h40);
        end
        applyStimulus(8'h00, 1'b0, 1'b1, 1'b0);
        checkOutput("en low ack", 1'b0, 3'b100, 8'h04, 1'b0);
        applyStimulus(8'h00, 1'b1, 1'b0, 1'b0);
        checkOutput("k2 grant", 1'b1, 3'b101, 8'h04, 1'b0);
        applyStimulus(8'h00, 1'b1, 1'b1, 1'b0);

        // Randomized traffic checked by the model on every cycle.
        for (int n = 0; n < 3000; n++) begin
            rd = 8'h00;
            for (int b = 0; b < 8; b++) begin
                rd[b] = ($urandom_range(0, 7) == 0);
            end
            applyStimulus(rd, ($urandom_range(0, 3) != 0), 1'($urandom_range(0, 1)),
                          ($urandom_range(0, 299) == 0));
        end

        @(posedge clk);
        #1;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/encode_8_3_seq.md
Name: encode_8_3_seq

Overview:
- Sequential 8-to-3 priority encoder; the inverse of the team's 3-to-8 dataflow decoder.
- Latches sticky request lines D[7:0], grants the highest-priority pending line, presents its 3-bit code C with a valid/ack handshake, and clears the line on acknowledge.
- C uses the decoder's input bit order, so C fed back into the decoder's I with En=1 asserts Y[k] for the granted line k (loopback-checkable).
- Used as the request/interrupt encoder in front of any block that consumes the decoder's code.

Parameters:
- None. Fixed 8 request lines, 3-bit code.

Ports:
- clk  input  1  rising-edge clock
- rst  input  1  reset, synchronous, active-high
- D  input  8  request lines; a line sampled high on any edge sets its pending bit
- En  input  1  grant enable; low blocks new grants
- Ack  input  1  consumer acknowledge; effective only while Valid=1
- C  output  3  code of the granted line
- Valid  output  1  C holds a granted, unacknowledged code
- Pend  output  8  current pending register (debug/status)
- Ovr  output  1  sticky overrun flag

Behaviour:
- One clock domain (clk). Reset is synchronous and active-high on rst. Everything below is sampled on the rising edge of clk.
- Reset (rst=1 at an edge), regardless of state or in-flight handshake:
  - Pend=8'h00, C=3'b000, Valid=0, Ovr=0, state=IDLE.
  - D and Ack are ignored on that edge.
- Code mapping for granted line k: C[0]*4 + C[1]*2 + C[2] = 7-k.
  - C[0] is the MSB of the code.
  - k=7 -> C=3'b000; k=0 -> C=3'b111 ({C[2],C[1],C[0]}).
- Priority: the highest index k with Pend[k]=1 wins.
- Pending update, every edge: Pend_next = (Pend & ~clr) | D.
  - clr is the one-hot mask of the granted line when Valid & Ack, else 0.
  - A request on the line being acked in that same cycle sets the bit again: the new request is kept, no overrun.
- Ovr sets when D[k]=1 and Pend[k]=1 on an edge where bit k is not being cleared that edge. Ovr stays set until reset.
- State machine, 2 states:
  - IDLE: Valid=0. If En=1 and Pend!=0, next edge: C <= code of the highest pending line, Valid <= 1, go to HOLD. The grant uses the registered Pend, not the same-cycle D.
  - HOLD: Valid=1. C and the granted index stay frozen; a higher-priority arrival does not preempt.
    - Ack=1: next edge Valid <= 0, clear the granted bit, go to IDLE.
    - Ack=0: stay in HOLD.
    - En falling during HOLD does not abort the grant.
- Latency and throughput:
  - D high at edge t -> Pend set at t -> Valid=1 at edge t+1 (if En=1).
  - Ack sampled at edge a -> Valid=0 at a; the next grant is valid at a+1.
  - Maximum rate: one grant per 2 cycles.
- Ack while Valid=0: ignored, no state change.
- En=0: requests still latch into Pend; no new grants; C retains its last value.
- Pend=0 in IDLE: stay in IDLE; C unchanged.

Test Plan:
- Reset mid-HOLD (Valid=1, Pend=8'hA0), rst=1 for one edge -> next cycle Pend=0, Valid=0, C=000, Ovr=0; Ack on that edge has no effect.
- Single request: D=8'h01 for one cycle, En=1, Ack held 0 -> Pend=8'h01, then Valid=1 with C=3'b111; hold 5 cycles unchanged; Ack=1 -> Valid=0, Pend=0.
- Priority order, lines 1, 4 and 5: D=8'h32 in one cycle, Ack=1 whenever Valid=1 -> grants in order:
  - k=5, C=3'b010
  - k=4, C=3'b110
  - k=1, C=3'b011
  - Each grant is spaced 2 cycles; Pend ends at 0.
- No preemption, plus overrun: D=8'h01 granted (C=111), then in HOLD D=8'h80 -> C stays 111. Second D=8'h80 before the ack -> Ovr=1. After the ack, the next grant is C=000.
- Same-cycle ack and re-request: Valid=1 for k=3 (C=3'b001), Ack=1 with D=8'h08 on the same edge -> Pend[3] stays 1, Ovr stays 0, re-grant C=001 one cycle later.
- En gating plus decoder loopback: En=0 with D=8'h44 -> Pend=8'h44, Valid stays 0. Raise En -> grant C=3'b100 (k=6). Feed C into the 3-to-8 decoder with En=1 -> decoder output 8'h40.
